// File: rtl/corefifo_wptr_ctrl_if.sv
// Write-side bus of the FIFO write-pointer controller: the write request and
// synchronized read pointer go in; the pointer, address, enable and flags come out.
interface corefifo_wptr_ctrl_if #(
  parameter int unsigned ADDRWIDTH = 3
);
  localparam int unsigned PW = ADDRWIDTH + 1;

  logic                 we;
  logic [PW-1:0]        rptr_gray_sync;
  logic [PW-1:0]        wptr_gray;
  logic [ADDRWIDTH-1:0] waddr;
  logic                 wen_mem;
  logic                 full;
  logic                 afull;
  logic                 overflow;
  logic [PW-1:0]        wrcnt;

  modport master (
    output we, rptr_gray_sync,
    input  wptr_gray, waddr, wen_mem, full, afull, overflow, wrcnt
  );

  modport slave (
    input  we, rptr_gray_sync,
    output wptr_gray, waddr, wen_mem, full, afull, overflow, wrcnt
  );
endinterface

// File: rtl/corefifo_wptr_ctrl.sv
// Write-domain pointer controller of an async FIFO: binary/Gray write pointer,
// fill level and full/almost-full/overflow flags against the synchronized read pointer.
module corefifo_wptr_ctrl #(
  parameter int unsigned ADDRWIDTH    = 3,
  parameter int unsigned AFULL_THRESH = 6
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  srstn,
  corefifo_wptr_ctrl_if.slave   bus
);
  localparam int unsigned PW = ADDRWIDTH + 1;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = int'(PW) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] r_wptr_bin;
  logic [PW-1:0] r_wptr_gray;
  logic [PW-1:0] r_wrcnt;
  logic          r_full;
  logic          r_afull;
  logic          r_overflow;

  logic          w_wen_mem;
  logic [PW-1:0] w_rptr_bin;
  logic [PW-1:0] w_wptr_bin_next;
  logic [PW-1:0] w_wptr_gray_next;
  logic [PW-1:0] w_full_match;
  logic [PW-1:0] w_wrcnt_next;
  logic          w_full_next;
  logic          w_afull_next;
  logic          w_overflow_next;

  // Next-state datapath; synchronous clear blocks the write and zeroes everything.
  always_comb begin
    w_wen_mem        = bus.we & ~r_full & srstn;
    w_rptr_bin       = gray2bin(bus.rptr_gray_sync);
    w_wptr_bin_next  = r_wptr_bin + PW'(w_wen_mem);
    w_wptr_gray_next = bin2gray(w_wptr_bin_next);
    w_full_match     = {~bus.rptr_gray_sync[PW-1:PW-2], bus.rptr_gray_sync[PW-3:0]};
    w_wrcnt_next     = w_wptr_bin_next - w_rptr_bin;
    w_full_next      = (w_wptr_gray_next == w_full_match);
    w_afull_next     = (w_wrcnt_next >= PW'(AFULL_THRESH));
    w_overflow_next  = bus.we & r_full;
    if (!srstn) begin
      w_wptr_bin_next  = '0;
      w_wptr_gray_next = '0;
      w_wrcnt_next     = '0;
      w_full_next      = 1'b0;
      w_afull_next     = 1'b0;
      w_overflow_next  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_wptr_bin  <= '0;
      r_wptr_gray <= '0;
      r_wrcnt     <= '0;
      r_full      <= 1'b0;
      r_afull     <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_wptr_bin  <= w_wptr_bin_next;
      r_wptr_gray <= w_wptr_gray_next;
      r_wrcnt     <= w_wrcnt_next;
      r_full      <= w_full_next;
      r_afull     <= w_afull_next;
      r_overflow  <= w_overflow_next;
    end
  end

  assign bus.wptr_gray = r_wptr_gray;
  assign bus.waddr     = r_wptr_bin[ADDRWIDTH-1:0];
  assign bus.wen_mem   = w_wen_mem;
  assign bus.full      = r_full;
  assign bus.afull     = r_afull;
  assign bus.overflow  = r_overflow;
  assign bus.wrcnt     = r_wrcnt;
endmodule

// File: tb/tb_corefifo_wptr_ctrl.sv
// Directed bench for corefifo_wptr_ctrl at ADDRWIDTH=3, AFULL_THRESH=6.
module tb_corefifo_wptr_ctrl;
  localparam int unsigned AW = 3;
  localparam int unsigned PW = AW + 1;

  logic clk;
  logic arstn;
  logic srstn;
  int   checks;
  int   errors;
  int   wraps;
  logic [PW-1:0] prev_gray;

  corefifo_wptr_ctrl_if #(.ADDRWIDTH(AW)) bus ();

  corefifo_wptr_ctrl #(.ADDRWIDTH(AW), .AFULL_THRESH(6)) dut (
    .clk   (clk),
    .arstn (arstn),
    .srstn (srstn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] g(input int n);
    logic [PW-1:0] b;
    b = PW'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".gray"},  32'(bus.wptr_gray), 32'h0);
    chk({tag, ".waddr"}, 32'(bus.waddr),     32'h0);
    chk({tag, ".wrcnt"}, 32'(bus.wrcnt),     32'h0);
    chk({tag, ".full"},  32'(bus.full),      32'h0);
    chk({tag, ".afull"}, 32'(bus.afull),     32'h0);
    chk({tag, ".ovf"},   32'(bus.overflow),  32'h0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    wraps  = 0;
    arstn  = 1'b0;
    srstn  = 1'b1;
    bus.we = 1'b0;
    bus.rptr_gray_sync = '0;
    #12;
    chk_zero("por");
    arstn = 1'b1;
    tick();

    // Fill to full with the read pointer parked at zero.
    bus.we = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("fill%0d.wrcnt", i), 32'(bus.wrcnt), 32'(i));
      chk($sformatf("fill%0d.afull", i), 32'(bus.afull), 32'(i >= 6));
      chk($sformatf("fill%0d.full", i),  32'(bus.full),  32'(i == 8));
    end
    bus.we = 1'b0;
    chk("fill.gray",  32'(bus.wptr_gray), 32'hC);
    chk("fill.waddr", 32'(bus.waddr),     32'h0);

    // One rejected write while full.
    bus.we = 1'b1;
    #1;
    chk("ovf.wen_mem", 32'(bus.wen_mem), 32'h0);
    tick();
    bus.we = 1'b0;
    chk("ovf.pulse", 32'(bus.overflow),  32'h1);
    chk("ovf.gray",  32'(bus.wptr_gray), 32'hC);
    chk("ovf.wrcnt", 32'(bus.wrcnt),     32'h8);
    tick();
    chk("ovf.clear", 32'(bus.overflow),  32'h0);

    // Drain two words via read-pointer advancement.
    bus.rptr_gray_sync = 4'b0001;
    tick();
    chk("drain1.full",  32'(bus.full),  32'h0);
    chk("drain1.wrcnt", 32'(bus.wrcnt), 32'h7);
    chk("drain1.afull", 32'(bus.afull), 32'h1);
    bus.rptr_gray_sync = 4'b0011;
    tick();
    chk("drain2.wrcnt", 32'(bus.wrcnt), 32'h6);
    chk("drain2.afull", 32'(bus.afull), 32'h1);
    tick();
    chk("drain3.wrcnt", 32'(bus.wrcnt), 32'h6);
    chk("drain3.full",  32'(bus.full),  32'h0);

    // Synchronous clear, then 40 writes with the reader two writes behind.
    srstn = 1'b0;
    bus.rptr_gray_sync = '0;
    tick();
    srstn = 1'b1;
    chk_zero("sclr");
    prev_gray = '0;
    for (int k = 1; k <= 40; k++) begin
      bus.we = 1'b1;
      bus.rptr_gray_sync = g((k - 3 > 0) ? k - 3 : 0);
      tick();
      chk($sformatf("wrap%0d.gray", k),  32'(bus.wptr_gray), 32'(g(k % 16)));
      chk($sformatf("wrap%0d.hd", k),    32'($countones(bus.wptr_gray ^ prev_gray)), 32'h1);
      chk($sformatf("wrap%0d.waddr", k), 32'(bus.waddr),     32'(k % 8));
      chk($sformatf("wrap%0d.full", k),  32'(bus.full),      32'h0);
      chk($sformatf("wrap%0d.ovf", k),   32'(bus.overflow),  32'h0);
      if (prev_gray == 4'b1000 && bus.wptr_gray == 4'b0000) wraps++;
      prev_gray = bus.wptr_gray;
    end
    bus.we = 1'b0;
    chk("wrap.count", 32'(wraps), 32'h2);

    // Mid-burst synchronous clear at count 5.
    srstn = 1'b0;
    bus.rptr_gray_sync = '0;
    tick();
    srstn = 1'b1;
    bus.we = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("burst%0d.wrcnt", k), 32'(bus.wrcnt), 32'(k));
    end
    srstn = 1'b0;
    #1;
    chk("burst.wen_mem_srst", 32'(bus.wen_mem), 32'h0);
    tick();
    srstn = 1'b1;
    chk_zero("burst.sclr");
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("resume%0d.wrcnt", k), 32'(bus.wrcnt), 32'(k));
    end
    chk("resume.full", 32'(bus.full), 32'h1);
    tick();
    chk("resume.ovf", 32'(bus.overflow), 32'h1);

    // Asynchronous reset mid-cycle with every flag set.
    #2;
    arstn  = 1'b0;
    bus.we = 1'b0;
    #1;
    chk_zero("arst");
    #3;
    arstn = 1'b1;
    tick();
    bus.we = 1'b1;
    tick();
    bus.we = 1'b0;
    chk("post_rst.wrcnt", 32'(bus.wrcnt),     32'h1);
    chk("post_rst.gray",  32'(bus.wptr_gray), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
